// File: rtl/fft_pkg.sv
// Shared defaults, state encoding and index types for the radix-2 FFT stage sequencer.
package fft_pkg;

    localparam int unsigned N_DEF       = 64;
    localparam int unsigned LOG2N_DEF   = 6;
    localparam int unsigned STAGE_W_DEF = $clog2(LOG2N_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic [LOG2N_DEF-1:0]   idx_t;
    typedef logic [LOG2N_DEF-2:0]   tw_t;
    typedef logic [STAGE_W_DEF-1:0] stage_t;

endpackage

// File: rtl/fft_stage_sequencer_index_gen.sv
// Combinational butterfly address generator: (stage, k) -> top/bottom operand and twiddle index.
module fft_index_gen
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = LOG2N_DEF
) (
    input  logic [$clog2(LOG2N)-1:0] stage,
    input  logic [LOG2N-2:0]         k,
    output logic [LOG2N-1:0]         idx_top_c,
    output logic [LOG2N-1:0]         idx_bot_c,
    output logic [LOG2N-2:0]         tw_idx_c
);

    localparam int unsigned SW = $clog2(LOG2N);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] top;
    logic [SW-1:0]    tw_shift;

    // pos < span <= N/2, so the twiddle fits in LOG2N-1 bits before shifting
    always_comb begin
        k_ext     = {1'b0, k};
        span      = LOG2N'(1) << stage;
        pos       = k_ext & (span - LOG2N'(1));
        grp       = k_ext >> stage;
        top       = ((grp << stage) << 1) | pos;
        tw_shift  = SW'(LOG2N - 1) - stage;
        idx_top_c = top;
        idx_bot_c = top + span;
        tw_idx_c  = pos[LOG2N-2:0] << tw_shift;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control FSM for the in-place radix-2 FFT: frame load, per-stage butterfly issue, pipeline drain, result hold.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned LOG2N  = LOG2N_DEF,
    parameter int unsigned BF_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     load,
    output logic                     bf_valid,
    input  logic                     bf_ready,
    output logic [LOG2N-1:0]         idx_top,
    output logic [LOG2N-1:0]         idx_bot,
    output logic [LOG2N-2:0]         tw_idx,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic                     busy
);

    localparam int unsigned SW = $clog2(LOG2N);
    localparam int unsigned KW = LOG2N - 1;
    localparam int unsigned CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(BF_LAT - 1);

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] k;
    logic [KW-1:0] k_next;
    logic [SW-1:0] stage_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          stage_end;

    logic [LOG2N-1:0] idx_top_c;
    logic [LOG2N-1:0] idx_bot_c;
    logic [LOG2N-2:0] tw_idx_c;

    // Addresses are generated for the next (stage, k) so they register alongside bf_valid
    fft_index_gen #(
        .LOG2N (LOG2N)
    ) u_index_gen (
        .stage     (stage_next),
        .k         (k_next),
        .idx_top_c (idx_top_c),
        .idx_bot_c (idx_bot_c),
        .tw_idx_c  (tw_idx_c)
    );

    always_comb begin
        state_next = state;
        k_next     = k;
        stage_next = stage;
        cnt_next   = cnt;
        stage_end  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if (bf_ready) begin
                    if (k == K_LAST) begin
                        if (BF_LAT == 0) begin
                            stage_end = 1'b1;
                        end else begin
                            state_next = DRAIN;
                            cnt_next   = '0;
                        end
                    end else begin
                        k_next = k + KW'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt == C_LAST) begin
                    stage_end = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    stage_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (stage_end) begin
            k_next = '0;
            if (stage == S_LAST) begin
                state_next = DONE;
            end else begin
                stage_next = stage + SW'(1);
                state_next = RUN;
            end
        end

        // Abort wins over every other transition, including a same-cycle in_valid/out_ready
        if (flush) begin
            state_next = IDLE;
            k_next     = '0;
            stage_next = '0;
            cnt_next   = '0;
        end
    end

    // Datapath registers update on the falling edge; outputs are registered next-state decodes
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            stage     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            load      <= 1'b0;
            bf_valid  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx_top   <= '0;
            idx_bot   <= '0;
            tw_idx    <= '0;
        end else begin
            state     <= state_next;
            k         <= k_next;
            stage     <= stage_next;
            cnt       <= cnt_next;
            in_ready  <= (state_next == IDLE);
            load      <= (state_next == LOAD);
            bf_valid  <= (state_next == RUN);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            idx_top   <= idx_top_c;
            idx_bot   <= idx_bot_c;
            tw_idx    <= tw_idx_c;
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: index table, butterfly scoreboard, timing and abort corner cases.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    typedef struct {
        int s;
        int top;
        int bot;
        int tw;
    } bf_exp_t;

    typedef struct {
        int s;
        int k;
        int top;
        int bot;
        int tw;
    } ig_vec_t;

    localparam int STALL_ACC = 32 + 7;

    logic   clk;
    logic   rst;
    logic   in_valid, bf_ready, out_ready, flush;
    logic   in_ready, load, bf_valid, out_valid, busy;
    idx_t   idx_top, idx_bot;
    tw_t    tw_idx;
    stage_t stage;

    logic       in_valid8, bf_ready8, out_ready8, flush8;
    logic       in_ready8, load8, bf_valid8, out_valid8, busy8;
    logic [2:0] idx_top8, idx_bot8;
    logic [1:0] tw_idx8, stage8;

    logic [2:0] ig_stage;
    logic [4:0] ig_k;
    logic [5:0] ig_top, ig_bot;
    logic [4:0] ig_tw;

    int vectors     = 0;
    int miscompares = 0;
    bf_exp_t q[$];
    ig_vec_t ig_tab[8];

    fft_stage_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .load(load),
        .bf_valid(bf_valid), .bf_ready(bf_ready), .idx_top(idx_top), .idx_bot(idx_bot),
        .tw_idx(tw_idx), .stage(stage), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .busy(busy)
    );

    fft_stage_sequencer #(.N(8), .LOG2N(3), .BF_LAT(0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .load(load8),
        .bf_valid(bf_valid8), .bf_ready(bf_ready8), .idx_top(idx_top8), .idx_bot(idx_bot8),
        .tw_idx(tw_idx8), .stage(stage8), .out_valid(out_valid8), .out_ready(out_ready8),
        .flush(flush8), .busy(busy8)
    );

    fft_index_gen #(.LOG2N(6)) u_ig (
        .stage(ig_stage), .k(ig_k), .idx_top_c(ig_top), .idx_bot_c(ig_bot), .tw_idx_c(ig_tw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bf(input string name, input bf_exp_t e);
        vectors++;
        if (int'(stage) !== e.s || int'(idx_top) !== e.top || int'(idx_bot) !== e.bot || int'(tw_idx) !== e.tw) begin
            miscompares++;
            $display("FAIL %s: got s=%0d top=%0d bot=%0d tw=%0d expected s=%0d top=%0d bot=%0d tw=%0d at %0t",
                     name, stage, idx_top, idx_bot, tw_idx, e.s, e.top, e.bot, e.tw, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_load"}, int'(load), 0);
        check({tag, "_bf_valid"}, int'(bf_valid), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_indices"}, int'({stage, idx_top, idx_bot, tw_idx}), 0);
    endtask

    // Reference ordering: group-major, position-minor within each stage (k = grp*span + pos)
    function automatic void push_frame();
        for (int s = 0; s < 6; s++) begin
            int span;
            span = 1 << s;
            for (int g = 0; g < 32 / span; g++) begin
                for (int p = 0; p < span; p++) begin
                    bf_exp_t e;
                    e.s   = s;
                    e.top = g * 2 * span + p;
                    e.bot = e.top + span;
                    e.tw  = p * (32 / span);
                    q.push_back(e);
                end
            end
        end
    endfunction

    // Starts at a rising edge with the DUT idle; that edge is cycle 0
    task automatic run_frame(input int stall_n, input int hold_n, input int abort_mode);
        int acc, stall_left, bfc, loads, load_cyc, done_cyc;
        bit done;
        bf_exp_t e;
        q.delete();
        push_frame();
        acc = 0; stall_left = stall_n; bfc = 0; loads = 0; load_cyc = -1; done_cyc = -1; done = 1'b0;
        check("idle_in_ready", int'(in_ready), 1);
        in_valid  = 1'b1;
        bf_ready  = 1'b1;
        out_ready = (hold_n == 0);
        for (int c = 0; c < 600 && !done; c++) begin
            if (load) begin
                loads++;
                load_cyc = c;
            end
            if (out_valid) begin
                done     = 1'b1;
                done_cyc = c;
            end else if (bf_valid) begin
                bfc++;
                if (abort_mode == 1 && acc == 100) begin
                    flush = 1'b1;
                    @(posedge clk);
                    check("flush_in_ready", int'(in_ready), 1);
                    check("flush_bf_valid", int'(bf_valid), 0);
                    check("flush_stage", int'(stage), 0);
                    check("flush_busy", int'(busy), 0);
                    check("flush_load", int'(load), 0);
                    flush    = 1'b0;
                    in_valid = 1'b0;
                    @(posedge clk);
                    check("flush_no_load", int'(load), 0);
                    check("flush_idle", int'(in_ready), 1);
                    return;
                end
                if (acc == STALL_ACC && stall_left > 0) begin
                    bf_ready = 1'b0;
                    stall_left--;
                    check_bf("bf_held", q[0]);
                end else begin
                    bf_ready = 1'b1;
                    if (q.size() == 0) begin
                        check("bf_overrun", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check_bf("bf_cmd", e);
                    end
                    acc++;
                end
            end else if (abort_mode == 2 && acc == 64 && busy && !load) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("rst_drain");
                @(posedge clk);
                rst      = 1'b1;
                in_valid = 1'b0;
                bf_ready = 1'b0;
                @(posedge clk);
                return;
            end
            if (!done) @(posedge clk);
        end
        if (!done) begin
            check("frame_timeout", 0, 1);
            rst = 1'b0;
            in_valid = 1'b0;
            @(posedge clk);
            rst = 1'b1;
            @(posedge clk);
            return;
        end
        check("out_valid_cycle", done_cyc, 206 + stall_n);
        check("bf_valid_cycles", bfc, 192 + stall_n);
        check("load_count", loads, 1);
        check("load_cycle", load_cyc, 1);
        check("queue_empty", q.size(), 0);
        for (int h = 0; h < hold_n; h++) begin
            @(posedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_load", int'(load), 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        check("release_out_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
        check("release_busy", int'(busy), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int bfc8;
        bit done8;

        rst = 1'b0;
        in_valid = 1'b0; bf_ready = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_valid8 = 1'b0; bf_ready8 = 1'b0; out_ready8 = 1'b0; flush8 = 1'b0;
        ig_stage = '0; ig_k = '0;

        ig_tab[0] = '{0, 5, 10, 11, 0};
        ig_tab[1] = '{2, 5, 9, 13, 8};
        ig_tab[2] = '{5, 31, 31, 63, 31};
        ig_tab[3] = '{1, 7, 13, 15, 16};
        ig_tab[4] = '{3, 20, 36, 44, 16};
        ig_tab[5] = '{4, 0, 0, 16, 0};
        ig_tab[6] = '{0, 31, 62, 63, 0};
        ig_tab[7] = '{5, 0, 0, 32, 0};

        repeat (2) @(posedge clk);
        check_reset_outputs("reset");
        check("reset_n8_in_ready", int'(in_ready8), 1);
        rst = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            ig_stage = 3'(ig_tab[i].s);
            ig_k     = 5'(ig_tab[i].k);
            #1;
            check($sformatf("ig_top_s%0d_k%0d", ig_tab[i].s, ig_tab[i].k), int'(ig_top), ig_tab[i].top);
            check($sformatf("ig_bot_s%0d_k%0d", ig_tab[i].s, ig_tab[i].k), int'(ig_bot), ig_tab[i].bot);
            check($sformatf("ig_tw_s%0d_k%0d", ig_tab[i].s, ig_tab[i].k), int'(ig_tw), ig_tab[i].tw);
        end
        @(posedge clk);

        run_frame(0, 0, 0);
        run_frame(3, 0, 0);
        run_frame(0, 10, 0);
        run_frame(0, 0, 1);

        // flush in IDLE must also suppress a same-cycle in_valid
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        check("idle_flush_load", int'(load), 0);
        check("idle_flush_in_ready", int'(in_ready), 1);
        flush = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        check("idle_flush_no_load", int'(load), 0);

        run_frame(0, 0, 2);
        run_frame(0, 0, 0);

        // N=8, BF_LAT=0 instance
        in_valid8 = 1'b1; bf_ready8 = 1'b1; out_ready8 = 1'b1;
        bfc8 = 0; done8 = 1'b0;
        for (int c = 0; c < 100 && !done8; c++) begin
            if (c == 0) check("n8_in_ready", int'(in_ready8), 1);
            if (c == 1) begin
                check("n8_load", int'(load8), 1);
                in_valid8 = 1'b0;
            end
            if (c == 2) check("n8_first_bf", int'({stage8, idx_top8, idx_bot8, tw_idx8}),
                              int'({2'd0, 3'd0, 3'd1, 2'd0}));
            if (c == 13) check("n8_last_bf", int'({stage8, idx_top8, idx_bot8, tw_idx8}),
                               int'({2'd2, 3'd3, 3'd7, 2'd3}));
            if (out_valid8) begin
                done8 = 1'b1;
                check("n8_done_cycle", c, 14);
            end else if (bf_valid8) begin
                bfc8++;
            end
            if (!done8) @(posedge clk);
        end
        check("n8_done_seen", int'(done8), 1);
        check("n8_bf_count", bfc8, 12);
        @(posedge clk);
        check("n8_idle_in_ready", int'(in_ready8), 1);
        check("n8_idle_busy", int'(busy8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
